// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and sizing for the reservation station and its issue scheduler.
package rs_issue_scheduler_pkg;
  localparam int RS_DEPTH = 16;
  localparam int IDX_W    = 4;
  localparam int NUM_FU   = 3;
  localparam int FU_W     = 2;

  typedef enum logic [FU_W-1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MEM  = 2'd2
  } fu_class_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } mem_state_e;
endpackage

// File: rtl/rs_age_select.sv
// Oldest-candidate picker: returns the candidate that no other candidate is older than.
module rs_age_select
  import rs_issue_scheduler_pkg::*;
(
  input  logic [RS_DEPTH-1:0]               cand,
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older,
  output logic                              found,
  output logic [IDX_W-1:0]                  idx
);
  logic [RS_DEPTH-1:0] oldest_s;

  // A candidate is oldest when no other candidate has its bit set in its column.
  always_comb begin
    oldest_s = '0;
    for (int j = 0; j < RS_DEPTH; j++) begin
      oldest_s[j] = cand[j];
      for (int i = 0; i < RS_DEPTH; i++) begin
        oldest_s[j] = oldest_s[j] & ~(cand[i] & older[i][j]);
      end
    end
  end

  // Encode the winner; lowest index breaks ties should the matrix ever be inconsistent.
  always_comb begin
    found = |oldest_s;
    idx   = '0;
    for (int j = RS_DEPTH - 1; j >= 0; j--) begin
      if (oldest_s[j]) begin
        idx = IDX_W'(j);
      end else begin
        idx = idx;
      end
    end
  end
endmodule

// File: rtl/rs_issue_scheduler.sv
// RS slot allocator, age tracker and per-FU oldest-ready issue select with mem-FU FSM.
// Optional macro RS_SCHED_PERF_EN adds perf_stall_cnt / perf_issue_cnt counters.
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    disp_req_a,
  input  logic [FU_W-1:0]         disp_fu_a,
  input  logic                    disp_req_b,
  input  logic [FU_W-1:0]         disp_fu_b,
  output logic                    disp_stall,
  output logic                    alloc_vld_a,
  output logic [IDX_W-1:0]        alloc_idx_a,
  output logic                    alloc_vld_b,
  output logic [IDX_W-1:0]        alloc_idx_b,
  input  logic [RS_DEPTH-1:0]     entry_ready,
  input  logic [1:0]              alu_rdy,
  input  logic                    mem_done,
  output logic [NUM_FU-1:0]       grant_vld,
  output logic [NUM_FU*IDX_W-1:0] grant_idx,
  output logic [IDX_W:0]          occupancy,
  output logic                    mem_busy
`ifdef RS_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_issue_cnt
`endif
);
  logic [RS_DEPTH-1:0]               valid_r;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_r;
  logic [FU_W-1:0]                   fu_tag_r [RS_DEPTH];
  mem_state_e                        mem_state_r;

  logic [IDX_W:0]                    free_cnt_s;
  logic [IDX_W-1:0]                  free0_s;
  logic [IDX_W-1:0]                  free1_s;
  logic [IDX_W:0]                    need_s;
  logic [IDX_W:0]                    alloc_cnt_s;
  logic [IDX_W:0]                    grant_cnt_s;
  logic [RS_DEPTH-1:0]               a_oh_s;
  logic [RS_DEPTH-1:0]               b_oh_s;
  logic [RS_DEPTH-1:0]               new_s;
  logic [RS_DEPTH-1:0]               keep_s;
  logic [RS_DEPTH-1:0]               grant_mask_s;
  logic [RS_DEPTH-1:0]               valid_next_s;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_next_s;
  logic [NUM_FU-1:0][RS_DEPTH-1:0]   cand_s;
  logic [NUM_FU-1:0]                 fu_gate_s;
  logic [NUM_FU-1:0]                 found_s;
  logic [NUM_FU-1:0][IDX_W-1:0]      win_idx_s;

  // Lowest and next-lowest free slot plus the free count.
  always_comb begin
    free_cnt_s = '0;
    free0_s    = '0;
    free1_s    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid_r[i]) begin
        if (free_cnt_s == (IDX_W+1)'(0)) begin
          free0_s = IDX_W'(i);
        end else if (free_cnt_s == (IDX_W+1)'(1)) begin
          free1_s = IDX_W'(i);
        end else begin
          free1_s = free1_s;
        end
        free_cnt_s = free_cnt_s + (IDX_W+1)'(1);
      end else begin
        free_cnt_s = free_cnt_s;
      end
    end
  end

  // Stall is all-or-nothing; a lone B request takes the lowest free slot.
  assign need_s      = (IDX_W+1)'(disp_req_a) + (IDX_W+1)'(disp_req_b);
  assign disp_stall  = (need_s > free_cnt_s) | flush;
  assign alloc_vld_a = disp_req_a & ~disp_stall;
  assign alloc_vld_b = disp_req_b & ~disp_stall;
  assign alloc_idx_a = free0_s;
  assign alloc_idx_b = disp_req_a ? free1_s : free0_s;
  assign alloc_cnt_s = (IDX_W+1)'(alloc_vld_a) + (IDX_W+1)'(alloc_vld_b);

  // Per-FU candidates; only registered-valid slots count, so fresh allocations are ignored.
  assign fu_gate_s = {mem_state_r == IDLE, alu_rdy};
  always_comb begin
    cand_s = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        cand_s[j][i] = valid_r[i] & entry_ready[i] & fu_gate_s[j] & (fu_tag_r[i] == FU_W'(j));
      end
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_sel
    rs_age_select u_sel (
      .cand  (cand_s[g]),
      .older (older_r),
      .found (found_s[g]),
      .idx   (win_idx_s[g])
    );
  end

  // Slots freed by this cycle's winners and the number of grants.
  always_comb begin
    grant_mask_s = '0;
    grant_cnt_s  = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      grant_mask_s = grant_mask_s | (found_s[j] ? (RS_DEPTH'(1'b1) << win_idx_s[j]) : {RS_DEPTH{1'b0}});
      grant_cnt_s  = grant_cnt_s + (IDX_W+1)'(found_s[j]);
    end
  end

  assign a_oh_s       = alloc_vld_a ? (RS_DEPTH'(1'b1) << alloc_idx_a) : {RS_DEPTH{1'b0}};
  assign b_oh_s       = alloc_vld_b ? (RS_DEPTH'(1'b1) << alloc_idx_b) : {RS_DEPTH{1'b0}};
  assign new_s        = a_oh_s | b_oh_s;
  assign keep_s       = valid_r & ~grant_mask_s;
  assign valid_next_s = keep_s | new_s;

  // New rows are younger than all survivors (A older than B); freed columns are cleared.
  always_comb begin
    older_next_s = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int k = 0; k < RS_DEPTH; k++) begin
        older_next_s[i][k] = new_s[i] ? (a_oh_s[i] & b_oh_s[k])
                           : (new_s[k] ? keep_s[i] : (older_r[i][k] & ~grant_mask_s[k]));
      end
    end
  end

  // Slot valid, age matrix and FU tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      older_r <= '0;
      for (int i = 0; i < RS_DEPTH; i++) fu_tag_r[i] <= '0;
    end else if (flush) begin
      valid_r <= '0;
      older_r <= '0;
    end else begin
      valid_r <= valid_next_s;
      older_r <= older_next_s;
      if (alloc_vld_a) fu_tag_r[alloc_idx_a] <= disp_fu_a;
      if (alloc_vld_b) fu_tag_r[alloc_idx_b] <= disp_fu_b;
    end
  end

  // Registered grants and occupancy; grant_idx holds when an FU gets nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_vld <= '0;
      grant_idx <= '0;
      occupancy <= '0;
    end else if (flush) begin
      grant_vld <= '0;
      occupancy <= '0;
    end else begin
      grant_vld <= found_s;
      for (int j = 0; j < NUM_FU; j++) begin
        if (found_s[j]) grant_idx[j*IDX_W +: IDX_W] <= win_idx_s[j];
      end
      occupancy <= occupancy + alloc_cnt_s - grant_cnt_s;
    end
  end

  // Memory-FU FSM; DRAIN waits out an op that was in flight when the RS was flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_state_r <= IDLE;
      mem_busy    <= 1'b0;
    end else begin
      case (mem_state_r)
        IDLE: begin
          if (!flush && found_s[NUM_FU-1]) begin
            mem_state_r <= BUSY;
            mem_busy    <= 1'b1;
          end else begin
            mem_state_r <= IDLE;
            mem_busy    <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_done) begin
            mem_state_r <= IDLE;
            mem_busy    <= 1'b0;
          end else if (flush) begin
            mem_state_r <= DRAIN;
            mem_busy    <= 1'b1;
          end else begin
            mem_state_r <= BUSY;
            mem_busy    <= 1'b1;
          end
        end
        DRAIN: begin
          if (mem_done) begin
            mem_state_r <= IDLE;
            mem_busy    <= 1'b0;
          end else begin
            mem_state_r <= DRAIN;
            mem_busy    <= 1'b1;
          end
        end
        default: begin
          mem_state_r <= IDLE;
          mem_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RS_SCHED_PERF_EN
  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
      perf_issue_cnt <= 32'd0;
    end else begin
      if (!flush && (need_s != (IDX_W+1)'(0)) && disp_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!flush) perf_issue_cnt <= perf_issue_cnt + 32'(grant_cnt_s);
    end
  end
`endif
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: expected grants queued per FU, checked by a monitor.
module tb_rs_issue_scheduler;
  import rs_issue_scheduler_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    flush = 1'b0;
  logic                    disp_req_a = 1'b0;
  logic [FU_W-1:0]         disp_fu_a = 2'd0;
  logic                    disp_req_b = 1'b0;
  logic [FU_W-1:0]         disp_fu_b = 2'd0;
  logic                    disp_stall;
  logic                    alloc_vld_a;
  logic [IDX_W-1:0]        alloc_idx_a;
  logic                    alloc_vld_b;
  logic [IDX_W-1:0]        alloc_idx_b;
  logic [RS_DEPTH-1:0]     entry_ready = 16'h0000;
  logic [1:0]              alu_rdy = 2'b11;
  logic                    mem_done = 1'b0;
  logic [NUM_FU-1:0]       grant_vld;
  logic [NUM_FU*IDX_W-1:0] grant_idx;
  logic [IDX_W:0]          occupancy;
  logic                    mem_busy;
`ifdef RS_SCHED_PERF_EN
  logic [31:0]             perf_stall_cnt;
  logic [31:0]             perf_issue_cnt;
`endif

  rs_issue_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .disp_req_a  (disp_req_a),
    .disp_fu_a   (disp_fu_a),
    .disp_req_b  (disp_req_b),
    .disp_fu_b   (disp_fu_b),
    .disp_stall  (disp_stall),
    .alloc_vld_a (alloc_vld_a),
    .alloc_idx_a (alloc_idx_a),
    .alloc_vld_b (alloc_vld_b),
    .alloc_idx_b (alloc_idx_b),
    .entry_ready (entry_ready),
    .alu_rdy     (alu_rdy),
    .mem_done    (mem_done),
    .grant_vld   (grant_vld),
    .grant_idx   (grant_idx),
    .occupancy   (occupancy),
    .mem_busy    (mem_busy)
`ifdef RS_SCHED_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_issue_cnt (perf_issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected grant of slot idx on FU fu, visible d edges after the current cycle.
  task automatic push(input int fu, input int idx, input int d);
    exp_t e;
    e.idx = idx;
    e.cyc = cyc + d;
    case (fu)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic disp(input logic ra, input logic [1:0] fa, input logic rb, input logic [1:0] fb);
    disp_req_a = ra;
    disp_fu_a  = fa;
    disp_req_b = rb;
    disp_fu_b  = fb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented grant must match the head of that FU's queue.
  always @(negedge clk) begin : mon
    exp_t e;
    int   qs;
    for (int j = 0; j < NUM_FU; j++) begin
      if (grant_vld[j] === 1'b1) begin
        qs = (j == 0) ? q0.size() : (j == 1) ? q1.size() : q2.size();
        if (qs == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_grant fu%0d: got slot %0d at cycle %0d, expected no grant",
                   j, grant_idx[j*IDX_W +: IDX_W], cyc);
        end else begin
          case (j)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          check($sformatf("grant_fu%0d_idx", j), int'(grant_idx[j*IDX_W +: IDX_W]), e.idx);
          check($sformatf("grant_fu%0d_cycle", j), cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_grant_vld", int'(grant_vld), 0);
    check("rst_grant_idx", int'(grant_idx), 0);
    check("rst_mem_busy", int'(mem_busy), 0);
    reset = 1'b0;
    tick();

    // 1: two fu0 dispatches, issued oldest first
    entry_ready = 16'h0003;
    disp(1'b1, 2'd0, 1'b1, 2'd0);
    #1;
    check("t1_alloc_vld_a", int'(alloc_vld_a), 1);
    check("t1_alloc_idx_a", int'(alloc_idx_a), 0);
    check("t1_alloc_vld_b", int'(alloc_vld_b), 1);
    check("t1_alloc_idx_b", int'(alloc_idx_b), 1);
    check("t1_stall", int'(disp_stall), 0);
    push(0, 0, 2);
    push(0, 1, 3);
    tick();
    disp(1'b0, 2'd0, 1'b0, 2'd0);
    check("t1_occ2", int'(occupancy), 2);
    tick();
    check("t1_occ1", int'(occupancy), 1);
    tick();
    check("t1_occ0", int'(occupancy), 0);
    entry_ready = 16'h0000;

    // 2: fill 15 slots, then stall rules at the full boundary
    for (int k = 0; k < 7; k++) begin
      disp(1'b1, 2'd1, 1'b1, 2'd1);
      tick();
    end
    disp(1'b1, 2'd1, 1'b0, 2'd0);
    tick();
    disp(1'b0, 2'd0, 1'b0, 2'd0);
    check("t2_occ15", int'(occupancy), 15);
    disp(1'b1, 2'd1, 1'b1, 2'd1);
    #1;
    check("t2_stall_ab", int'(disp_stall), 1);
    check("t2_vld_a_stalled", int'(alloc_vld_a), 0);
    check("t2_vld_b_stalled", int'(alloc_vld_b), 0);
    disp(1'b1, 2'd1, 1'b0, 2'd0);
    #1;
    check("t2_stall_a", int'(disp_stall), 0);
    check("t2_vld_a", int'(alloc_vld_a), 1);
    check("t2_idx_a15", int'(alloc_idx_a), 15);
    tick();
    check("t2_occ16", int'(occupancy), 16);
    check("t2_stall_full", int'(disp_stall), 1);
    disp(1'b0, 2'd0, 1'b0, 2'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t2_flush_occ", int'(occupancy), 0);

    // 3: reallocated slot 0 is youngest, so slot 3 wins fu1 first
    disp(1'b0, 2'd0, 1'b1, 2'd0);
    #1;
    check("t3_b_only_vld_a", int'(alloc_vld_a), 0);
    check("t3_b_only_idx", int'(alloc_idx_b), 0);
    tick();
    disp(1'b1, 2'd1, 1'b1, 2'd1);
    tick();
    disp(1'b1, 2'd1, 1'b0, 2'd0);
    entry_ready = 16'h0001;
    push(0, 0, 1);
    tick();
    entry_ready = 16'h0000;
    #1;
    check("t3_realloc_idx", int'(alloc_idx_a), 0);
    tick();
    disp(1'b0, 2'd0, 1'b0, 2'd0);
    entry_ready = 16'h0009;
    push(1, 3, 1);
    push(1, 0, 2);
    tick();
    tick();
    entry_ready = 16'h0000;
    check("t3_occ", int'(occupancy), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // 4: mem FU serialises two ready fu2 entries
    disp(1'b1, 2'd2, 1'b1, 2'd2);
    tick();
    disp(1'b0, 2'd0, 1'b0, 2'd0);
    entry_ready = 16'h0003;
    push(2, 0, 1);
    tick();
    check("t4_busy", int'(mem_busy), 1);
    repeat (3) tick();
    mem_done = 1'b1;
    push(2, 1, 2);
    tick();
    mem_done = 1'b0;
    check("t4_idle", int'(mem_busy), 0);
    tick();
    check("t4_busy2", int'(mem_busy), 1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    entry_ready = 16'h0000;
    check("t4_idle2", int'(mem_busy), 0);

    // 5: flush while BUSY goes to DRAIN and blocks fu2 until mem_done
    disp(1'b1, 2'd2, 1'b1, 2'd2);
    tick();
    disp(1'b0, 2'd0, 1'b0, 2'd0);
    entry_ready = 16'h0003;
    push(2, 0, 1);
    tick();
    check("t5_busy", int'(mem_busy), 1);
    flush = 1'b1;
    disp(1'b1, 2'd2, 1'b0, 2'd0);
    #1;
    check("t5_flush_stall", int'(disp_stall), 1);
    check("t5_flush_no_alloc", int'(alloc_vld_a), 0);
    tick();
    flush = 1'b0;
    check("t5_occ", int'(occupancy), 0);
    check("t5_grant_vld", int'(grant_vld), 0);
    check("t5_drain_busy", int'(mem_busy), 1);
    #1;
    check("t5_alloc_idx", int'(alloc_idx_a), 0);
    tick();
    disp(1'b0, 2'd0, 1'b0, 2'd0);
    repeat (2) tick();
    mem_done = 1'b1;
    push(2, 0, 2);
    tick();
    mem_done = 1'b0;
    check("t5_idle", int'(mem_busy), 0);
    tick();
    check("t5_busy2", int'(mem_busy), 1);
    flush = 1'b1;
    mem_done = 1'b1;
    tick();
    flush = 1'b0;
    mem_done = 1'b0;
    entry_ready = 16'h0000;
    check("t5_flush_done_idle", int'(mem_busy), 0);

    // 6: async reset between edges clears outputs immediately
    disp(1'b1, 2'd2, 1'b1, 2'd0);
    tick();
    entry_ready = 16'h0003;
    disp(1'b1, 2'd1, 1'b0, 2'd0);
    #1;
    check("t6_alloc_idx", int'(alloc_idx_a), 2);
    push(2, 0, 1);
    push(0, 1, 1);
    tick();
    disp(1'b0, 2'd0, 1'b0, 2'd0);
    check("t6_occ", int'(occupancy), 1);
    check("t6_busy", int'(mem_busy), 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_occ", int'(occupancy), 0);
    check("t6_rst_grant_vld", int'(grant_vld), 0);
    check("t6_rst_grant_idx", int'(grant_idx), 0);
    check("t6_rst_busy", int'(mem_busy), 0);
    entry_ready = 16'h0000;
    tick();
    reset = 1'b0;
    tick();

    check("q_fu0_left", q0.size(), 0);
    check("q_fu1_left", q1.size(), 0);
    check("q_fu2_left", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Slot allocator and issue arbiter for the 16-entry reservation station.
- Allocates RS slots to up to two dispatching instructions per cycle and tracks the relative age of occupied slots.
- Each cycle, grants the oldest ready entry to each of the three FUs: FU0/FU1 are ALUs, FU2 is the memory unit.
- Owns the memory-FU occupancy state machine, so a multi-cycle load/store is never double-issued.

Parameters:
- RS_DEPTH, 16, number of RS slots (power of two).
- IDX_W, 4, log2(RS_DEPTH).
- NUM_FU, 3, FU classes (0, 1 = ALU; 2 = mem).
- FU_W, 2, width of FU class code.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all RS entries (mispredict recovery)
- disp_req_a  in  1  dispatch slot A valid (older of the pair)
- disp_fu_a  in  FU_W  FU class of A
- disp_req_b  in  1  dispatch slot B valid
- disp_fu_b  in  FU_W  FU class of B
- disp_stall  out  1  insufficient free slots; no allocation this cycle
- alloc_vld_a  out  1  A allocated this cycle
- alloc_idx_a  out  IDX_W  slot index for A
- alloc_vld_b  out  1  B allocated this cycle
- alloc_idx_b  out  IDX_W  slot index for B
- entry_ready  in  RS_DEPTH  per-slot src1rdy & src2rdy from the RS table
- alu_rdy  in  2  FU0/FU1 can accept an issue
- mem_done  in  1  mem FU finished its in-flight op (1-cycle pulse)
- grant_vld  out  NUM_FU  registered issue grant per FU
- grant_idx  out  NUM_FU*IDX_W  registered slot index per FU; FU j occupies bits [j*IDX_W +: IDX_W]
- occupancy  out  IDX_W+1  registered count of valid slots
- mem_busy  out  1  mem FSM not IDLE

Behaviour:
- Reset (async): slot valid = 0, age matrix = 0, fu tags = 0, grant_vld = 0, grant_idx = 0, occupancy = 0, mem FSM = IDLE. The same values apply if reset asserts mid-operation.

Allocation (combinational, from registered valid):
- free = ~valid. alloc_idx_a = lowest free index; alloc_idx_b = next-lowest free index.
- If only B is requested, B takes the lowest free index.
- need = disp_req_a + disp_req_b. disp_stall = (need > free count) | flush.
- alloc_vld_x = disp_req_x & ~disp_stall. Stall is all-or-nothing.
- A slot freed by a grant at edge N is allocatable from cycle N+1 only.

Dispatch write (posedge):
- For each allocated slot: valid = 1; fu tag stored.
- Age row set: every currently valid slot is older than the new entry; A is older than B.
- Age matrix: older[i][j] = 1 means i is older than j. The column for a freed slot is cleared on free.

Select (combinational; result registered):
- cand_j = valid & entry_ready & (fu tag == j).
- FU0/FU1 additionally gated by alu_rdy[j]; FU2 gated by mem FSM == IDLE.
- Winner = the candidate with no older candidate; at most one per FU. FU classes are disjoint, so there are no cross-FU conflicts.
- At posedge: grant_vld[j] <= winner exists; grant_idx[j] <= winner index, held when there is no grant; the winner's valid is cleared.
- Latency: ready at cycle N -> grant_vld at N+1.
- entry_ready is ignored for invalid slots, including slots being written this edge.

Mem FSM:
- IDLE -> BUSY on a FU2 grant.
- BUSY -> IDLE on mem_done.
- BUSY -> DRAIN on flush without mem_done.
- DRAIN -> IDLE on mem_done.
- mem_done in IDLE is ignored.
- No FU2 grant is made in BUSY or DRAIN. After returning to IDLE, a FU2 grant is selected in the following cycle.

Flush (priority over dispatch and select):
- At the edge: all valid = 0, age = 0, grant_vld = 0, occupancy = 0.
- Mem FSM as above; flush with simultaneous mem_done -> IDLE.

Occupancy: occupancy <= occupancy + allocs − grants. The value never exceeds RS_DEPTH.

Optional Feature:
- Macro: RS_SCHED_PERF_EN.
- Defined:
  - adds outputs perf_stall_cnt (32) = cycles with need > 0 & disp_stall & ~flush;
  - adds perf_issue_cnt (32) = total grants (grant_vld bits summed per cycle);
  - both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared typedefs package gets:
  - FU class enum (FU_ALU0 = 0, FU_ALU1 = 1, FU_MEM = 2);
  - mem FSM state enum (IDLE, BUSY, DRAIN);
  - RS_DEPTH / IDX_W constants, shared with the reservation station.
- One sub-module: rs_age_select. It is a pure combinational oldest-candidate picker (candidate vector + age matrix -> found, index), instantiated NUM_FU times.

Test Plan:
1. Reset, then dispatch A = fu0, B = fu0 with both entry_ready = 1 -> alloc_idx 0/1; next cycle grant_idx[0] = 0; the cycle after, grant_idx[0] = 1; occupancy 2 -> 1 -> 0.
2. Fill 15 slots, then request A + B -> disp_stall = 1, no alloc_vld. Request only A -> alloc_idx_a = 15, occupancy = 16.
3. Allocate slots 0..3, grant slot 0, reallocate slot 0 (youngest), make slots 0 and 3 ready on fu1 -> slot 3 granted first.
4. Two ready fu2 entries -> first grant, mem_busy = 1, no second grant until mem_done pulse. The second grant follows one cycle after the FSM returns to IDLE.
5. Flush while mem BUSY -> valid cleared, grant_vld = 0, FSM = DRAIN; ready fu2 entries are blocked until mem_done -> IDLE.
6. Assert async reset mid-stream (between edges) -> all outputs 0 immediately, mem_busy = 0.
